// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared widths, ALU opcodes and types for the ID/EX stage.
// The guarded defaults let an external rvseed_defines.v take precedence.
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif
`ifndef ALU_OP_WIDTH
`define ALU_OP_WIDTH 4
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef ALU_ADD
`define ALU_ADD 4'd0
`define ALU_SUB 4'd1
`define ALU_AND 4'd2
`define ALU_OR  4'd3
`define ALU_XOR 4'd4
`define ALU_SLL 4'd5
`define ALU_SRL 4'd6
`define ALU_SRA 4'd7
`define ALU_SLT 4'd8
`define ALU_SLTU 4'd9
`endif

package id_ex_stage_pkg;
    localparam int XLEN = `CPU_WIDTH;
    localparam int OPW  = `ALU_OP_WIDTH;
    localparam int RAW  = `REG_ADDR_WIDTH;
    typedef logic [XLEN-1:0] word_t;
    typedef logic [OPW-1:0]  op_t;
    typedef logic [RAW-1:0]  reg_t;
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: priority operand forwarding EX > MEM > WB > register file; x0 never forwards.
module fwd_mux
    import id_ex_stage_pkg::*;
(
    input  reg_t  addr,
    input  word_t rf_data,
    input  logic  ex_en,
    input  reg_t  ex_addr,
    input  word_t ex_data,
    input  logic  mem_en,
    input  reg_t  mem_addr,
    input  word_t mem_data,
    input  logic  wb_en,
    input  reg_t  wb_addr,
    input  word_t wb_data,
    output word_t data
);
    logic nz;
    assign nz = addr != '0;
    assign data = (nz && ex_en  && ex_addr  == addr) ? ex_data  :
                  (nz && mem_en && mem_addr == addr) ? mem_data :
                  (nz && wb_en  && wb_addr  == addr) ? wb_data  : rf_data;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with forwarding, ALU source select,
// load-use stall, backpressure hold and flush.
module id_ex_stage
    import id_ex_stage_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  id_valid,
    output logic  id_ready,
    input  op_t   id_alu_op,
    input  word_t id_inst,
    input  word_t id_pc,
    input  word_t id_imm,
    input  reg_t  id_rs1_addr,
    input  reg_t  id_rs2_addr,
    input  word_t id_rs1_data,
    input  word_t id_rs2_data,
    input  logic  id_rs1_used,
    input  logic  id_rs2_used,
    input  logic  id_src1_sel,
    input  logic  id_src2_sel,
    input  reg_t  id_rd_addr,
    input  logic  id_rd_wen,
    input  logic  id_is_load,
    input  logic  ex_ready,
    input  logic  flush,
    input  word_t ex_alu_res,
    input  logic  mem_rd_wen,
    input  reg_t  mem_rd_addr,
    input  word_t mem_rd_data,
    input  logic  wb_rd_wen,
    input  reg_t  wb_rd_addr,
    input  word_t wb_rd_data,
    output logic  ex_valid,
    output op_t   alu_op,
    output word_t alu_src1,
    output word_t alu_src2,
    output word_t inst,
    output word_t ex_pc,
    output word_t ex_rs2_data,
    output reg_t  ex_rd_addr,
    output logic  ex_rd_wen,
    output logic  ex_is_load
);
    logic  hold, lu, ex_fwd_en;
    word_t fwd_rs1, fwd_rs2;

    assign hold      = ex_valid & ~ex_ready;
    assign ex_fwd_en = ex_valid & ex_rd_wen & ~ex_is_load;
    // A load result only exists after MEM, so a dependent ID instruction waits one cycle.
    assign lu = ex_valid & ex_is_load & ex_rd_wen & (ex_rd_addr != '0) &
                ((id_rs1_used & (ex_rd_addr == id_rs1_addr)) |
                 (id_rs2_used & (ex_rd_addr == id_rs2_addr)));
    assign id_ready = ~hold & ~lu;

    fwd_mux u_fwd_rs1 (
        .addr(id_rs1_addr), .rf_data(id_rs1_data),
        .ex_en(ex_fwd_en), .ex_addr(ex_rd_addr), .ex_data(ex_alu_res),
        .mem_en(mem_rd_wen), .mem_addr(mem_rd_addr), .mem_data(mem_rd_data),
        .wb_en(wb_rd_wen), .wb_addr(wb_rd_addr), .wb_data(wb_rd_data),
        .data(fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .addr(id_rs2_addr), .rf_data(id_rs2_data),
        .ex_en(ex_fwd_en), .ex_addr(ex_rd_addr), .ex_data(ex_alu_res),
        .mem_en(mem_rd_wen), .mem_addr(mem_rd_addr), .mem_data(mem_rd_data),
        .wb_en(wb_rd_wen), .wb_addr(wb_rd_addr), .wb_data(wb_rd_data),
        .data(fwd_rs2)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            alu_op      <= '0;
            alu_src1    <= '0;
            alu_src2    <= '0;
            inst        <= '0;
            ex_pc       <= '0;
            ex_rs2_data <= '0;
            ex_rd_addr  <= '0;
            ex_rd_wen   <= 1'b0;
            ex_is_load  <= 1'b0;
        end else if (flush) begin
            ex_valid   <= 1'b0;
            ex_rd_wen  <= 1'b0;
            ex_is_load <= 1'b0;
        end else if (hold) begin
        end else if (id_valid && id_ready) begin
            ex_valid    <= 1'b1;
            alu_op      <= id_alu_op;
            alu_src1    <= id_src1_sel ? id_pc : fwd_rs1;
            alu_src2    <= id_src2_sel ? id_imm : fwd_rs2;
            inst        <= id_inst;
            ex_pc       <= id_pc;
            ex_rs2_data <= fwd_rs2;
            ex_rd_addr  <= id_rd_addr;
            ex_rd_wen   <= id_rd_wen;
            ex_is_load  <= id_is_load;
        end else begin
            ex_valid   <= 1'b0;
            ex_rd_wen  <= 1'b0;
            ex_is_load <= 1'b0;
            alu_op     <= '0;
            alu_src1   <= '0;
            alu_src2   <= '0;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic  clk, rst_n, id_valid, id_ready;
    op_t   id_alu_op, alu_op;
    word_t id_inst, id_pc, id_imm, id_rs1_data, id_rs2_data;
    reg_t  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic  id_rs1_used, id_rs2_used, id_src1_sel, id_src2_sel, id_rd_wen, id_is_load;
    logic  ex_ready, flush, mem_rd_wen, wb_rd_wen;
    word_t ex_alu_res, mem_rd_data, wb_rd_data;
    reg_t  mem_rd_addr, wb_rd_addr, ex_rd_addr;
    logic  ex_valid, ex_rd_wen, ex_is_load;
    word_t alu_src1, alu_src2, inst, ex_pc, ex_rs2_data;

    int passed = 0;
    int total  = 0;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
        .id_alu_op(id_alu_op), .id_inst(id_inst), .id_pc(id_pc), .id_imm(id_imm),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_src1_sel(id_src1_sel), .id_src2_sel(id_src2_sel),
        .id_rd_addr(id_rd_addr), .id_rd_wen(id_rd_wen), .id_is_load(id_is_load),
        .ex_ready(ex_ready), .flush(flush), .ex_alu_res(ex_alu_res),
        .mem_rd_wen(mem_rd_wen), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .wb_rd_wen(wb_rd_wen), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
        .ex_valid(ex_valid), .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .inst(inst), .ex_pc(ex_pc), .ex_rs2_data(ex_rs2_data),
        .ex_rd_addr(ex_rd_addr), .ex_rd_wen(ex_rd_wen), .ex_is_load(ex_is_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input op_t op, input reg_t r1, input reg_t r2, input word_t d1,
                         input word_t d2, input reg_t rd, input logic ld);
        id_valid    = 1'b1;
        id_alu_op   = op;
        id_inst     = {7'h0, r2, r1, 3'h0, rd, 7'h33};
        id_pc       = 32'h100;
        id_imm      = 32'h4;
        id_rs1_addr = r1;
        id_rs2_addr = r2;
        id_rs1_data = d1;
        id_rs2_data = d2;
        id_rs1_used = 1'b1;
        id_rs2_used = 1'b1;
        id_src1_sel = 1'b0;
        id_src2_sel = 1'b0;
        id_rd_addr  = rd;
        id_rd_wen   = 1'b1;
        id_is_load  = ld;
    endtask

    task automatic clear_fwd();
        mem_rd_wen = 1'b0; mem_rd_addr = '0; mem_rd_data = '0;
        wb_rd_wen  = 1'b0; wb_rd_addr  = '0; wb_rd_data  = '0;
    endtask

    initial begin
        rst_n = 1'b0; ex_ready = 1'b1; flush = 1'b0; ex_alu_res = '0;
        clear_fwd();
        issue(`ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd7, 5'd3, 1'b0);
        id_valid = 1'b0;
        tick(); tick();
        chk("rst_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_op", {28'b0, alu_op}, 32'd0);
        chk("rst_src1", alu_src1, 32'd0);
        chk("rst_rd_wen", {31'b0, ex_rd_wen}, 32'd0);

        rst_n = 1'b1;
        issue(`ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd7, 5'd3, 1'b0);
        tick();
        chk("add_valid", {31'b0, ex_valid}, 32'd1);
        chk("add_src1", alu_src1, 32'd5);
        chk("add_src2", alu_src2, 32'd7);
        chk("add_op", {28'b0, alu_op}, {28'b0, `ALU_ADD});
        chk("add_rd", {27'b0, ex_rd_addr}, 32'd3);

        rst_n = 1'b0;
        tick();
        chk("midrst_valid", {31'b0, ex_valid}, 32'd0);
        chk("midrst_src1", alu_src1, 32'd0);
        chk("midrst_src2", alu_src2, 32'd0);
        chk("midrst_inst", inst, 32'd0);
        chk("midrst_pc", ex_pc, 32'd0);
        rst_n = 1'b1;

        issue(`ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd7, 5'd5, 1'b0);
        tick();
        ex_alu_res = 32'd12;
        issue(`ALU_SUB, 5'd5, 5'd1, 32'd99, 32'd5, 5'd6, 1'b0);
        #1 chk("fwd_ex_ready", {31'b0, id_ready}, 32'd1);
        tick();
        chk("fwd_ex_src1", alu_src1, 32'd12);
        chk("fwd_ex_src2", alu_src2, 32'd5);
        chk("fwd_ex_op", {28'b0, alu_op}, {28'b0, `ALU_SUB});

        mem_rd_wen = 1'b1; mem_rd_addr = 5'd5; mem_rd_data = 32'd12;
        issue(`ALU_SUB, 5'd5, 5'd1, 32'd99, 32'd5, 5'd7, 1'b0);
        tick();
        chk("fwd_mem_src1", alu_src1, 32'd12);
        clear_fwd();

        wb_rd_wen = 1'b1; wb_rd_addr = 5'd5; wb_rd_data = 32'd12;
        issue(`ALU_SUB, 5'd5, 5'd1, 32'd99, 32'd5, 5'd8, 1'b0);
        tick();
        chk("fwd_wb_src1", alu_src1, 32'd12);
        clear_fwd();

        issue(`ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd7, 5'd5, 1'b0);
        tick();
        ex_alu_res = 32'd12;
        mem_rd_wen = 1'b1; mem_rd_addr = 5'd5; mem_rd_data = 32'd34;
        wb_rd_wen = 1'b1; wb_rd_addr = 5'd5; wb_rd_data = 32'd56;
        issue(`ALU_SUB, 5'd1, 5'd5, 32'd5, 32'd99, 5'd9, 1'b0);
        tick();
        chk("fwd_prio_src2", alu_src2, 32'd12);
        chk("fwd_prio_rs2d", ex_rs2_data, 32'd12);
        issue(`ALU_SUB, 5'd5, 5'd1, 32'd99, 32'd5, 5'd9, 1'b0);
        tick();
        chk("fwd_mem_over_wb", alu_src1, 32'd34);
        clear_fwd();

        issue(`ALU_ADD, 5'd1, 5'd0, 32'd5, 32'd0, 5'd7, 1'b1);
        tick();
        chk("lw_is_load", {31'b0, ex_is_load}, 32'd1);
        issue(`ALU_ADD, 5'd7, 5'd1, 32'd0, 32'd5, 5'd10, 1'b0);
        #1 chk("lu_ready", {31'b0, id_ready}, 32'd0);
        tick();
        chk("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
        chk("lu_bubble_wen", {31'b0, ex_rd_wen}, 32'd0);
        chk("lu_bubble_src1", alu_src1, 32'd0);
        chk("lu_ready_after", {31'b0, id_ready}, 32'd1);
        mem_rd_wen = 1'b1; mem_rd_addr = 5'd7; mem_rd_data = 32'hDEAD_BEEF;
        tick();
        chk("lu_cap_valid", {31'b0, ex_valid}, 32'd1);
        chk("lu_cap_src1", alu_src1, 32'hDEAD_BEEF);
        chk("lu_cap_rd", {27'b0, ex_rd_addr}, 32'd10);
        clear_fwd();

        ex_ready = 1'b0;
        issue(`ALU_OR, 5'd12, 5'd13, 32'd1, 32'd2, 5'd11, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("hold_ready", {31'b0, id_ready}, 32'd0);
            tick();
            chk("hold_valid", {31'b0, ex_valid}, 32'd1);
            chk("hold_src1", alu_src1, 32'hDEAD_BEEF);
            chk("hold_rd", {27'b0, ex_rd_addr}, 32'd10);
        end
        ex_ready = 1'b1;
        #1 chk("release_ready", {31'b0, id_ready}, 32'd1);
        tick();
        chk("release_rd", {27'b0, ex_rd_addr}, 32'd11);
        chk("release_src1", alu_src1, 32'd1);
        chk("release_op", {28'b0, alu_op}, {28'b0, `ALU_OR});

        ex_ready = 1'b0; flush = 1'b1;
        issue(`ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd7, 5'd13, 1'b0);
        tick();
        chk("flush_hold_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush_hold_wen", {31'b0, ex_rd_wen}, 32'd0);
        ex_ready = 1'b1;
        issue(`ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd7, 5'd14, 1'b0);
        tick();
        chk("flush_in_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush_in_rd", {27'b0, ex_rd_addr}, 32'd11);
        flush = 1'b0;

        issue(`ALU_ADD, 5'd1, 5'd0, 32'd5, 32'd0, 5'd7, 1'b1);
        tick();
        issue(`ALU_ADD, 5'd7, 5'd1, 32'd0, 32'd5, 5'd15, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_lu_valid", {31'b0, ex_valid}, 32'd0);
        chk("flush_lu_load", {31'b0, ex_is_load}, 32'd0);
        #1 chk("flush_lu_ready", {31'b0, id_ready}, 32'd1);

        issue(`ALU_ADD, 5'd1, 5'd2, 32'd5, 32'd7, 5'd0, 1'b0);
        tick();
        ex_alu_res = 32'h55;
        mem_rd_wen = 1'b1; mem_rd_addr = 5'd0; mem_rd_data = 32'h55;
        wb_rd_wen = 1'b1; wb_rd_addr = 5'd0; wb_rd_data = 32'h55;
        issue(`ALU_ADD, 5'd0, 5'd0, 32'd0, 32'd0, 5'd16, 1'b0);
        #1 chk("x0_ready", {31'b0, id_ready}, 32'd1);
        tick();
        chk("x0_src1", alu_src1, 32'd0);
        chk("x0_rs2d", ex_rs2_data, 32'd0);
        clear_fwd();

        issue(`ALU_ADD, 5'd0, 5'd0, 32'd0, 32'd0, 5'd17, 1'b0);
        id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        id_src1_sel = 1'b1; id_src2_sel = 1'b1;
        id_pc = 32'h80; id_imm = 32'h1000;
        tick();
        chk("auipc_src1", alu_src1, 32'h80);
        chk("auipc_src2", alu_src2, 32'h1000);
        chk("auipc_pc", ex_pc, 32'h80);

        id_valid = 1'b0;
        tick();
        chk("idle_valid", {31'b0, ex_valid}, 32'd0);
        chk("idle_src2", alu_src2, 32'd0);
        chk("idle_wen", {31'b0, ex_rd_wen}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
